// File: rtl/tri_raster_scan.sv
// tri_raster_scan: one-triangle-at-a-time rasterizer that clips a bounding box to the screen and walks it with incremental edge functions.
// Optional `define TRI_RASTER_TOP_LEFT_EN applies the top-left fill rule to zero-valued edges.
module tri_raster_scan #(
    parameter int COORD_W  = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int EW       = 2*COORD_W+2
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_tri_valid,
    output logic                      o_tri_ready,
    input  logic signed [COORD_W-1:0] i_v1x,
    input  logic signed [COORD_W-1:0] i_v1y,
    input  logic signed [COORD_W-1:0] i_v2x,
    input  logic signed [COORD_W-1:0] i_v2y,
    input  logic signed [COORD_W-1:0] i_v3x,
    input  logic signed [COORD_W-1:0] i_v3y,
    output logic                      o_pix_valid,
    input  logic                      i_pix_ready,
    output logic signed [COORD_W-1:0] o_pix_x,
    output logic signed [COORD_W-1:0] o_pix_y,
    output logic signed [EW-1:0]      o_pix_w1,
    output logic signed [EW-1:0]      o_pix_w2,
    output logic signed [EW-1:0]      o_pix_w3,
    output logic signed [EW-1:0]      o_pix_area,
    output logic                      o_done,
    output logic                      o_busy
);
    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    localparam logic signed [EW-1:0]      X_LIM = EW'(SCREEN_W - 1);
    localparam logic signed [EW-1:0]      Y_LIM = EW'(SCREEN_H - 1);
    localparam logic signed [COORD_W-1:0] ONE_C = COORD_W'(1);

    state_t state, state_nx;

    logic signed [COORD_W-1:0] vx [3];
    logic signed [COORD_W-1:0] vy [3];
    logic signed [EW-1:0]      ex [3];
    logic signed [EW-1:0]      ey [3];
    logic signed [EW-1:0]      dx [3];
    logic signed [EW-1:0]      dy [3];
    logic signed [EW-1:0]      e_raw [3];
    logic signed [EW-1:0]      e_start [3];
    logic signed [EW-1:0]      area_raw;
    logic                      neg;
    logic signed [EW-1:0]      xlo, xhi, ylo, yhi;
    logic signed [EW-1:0]      xmin_c, xmax_c, ymin_c, ymax_c;
    logic                      off_screen;

    logic signed [EW-1:0]      e_cur [3];
    logic signed [EW-1:0]      e_row [3];
    logic signed [EW-1:0]      step_x [3];
    logic signed [EW-1:0]      step_y [3];
    logic signed [EW-1:0]      area;
    logic signed [COORD_W-1:0] cx, cy, xmin, xmax, ymax;
    logic [2:0]                cov;
    logic                      covered, advance, last;

    // Setup math runs on the latched vertices; winding is normalised by negating every coefficient.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ex[i] = {{(EW-COORD_W){vx[i][COORD_W-1]}}, vx[i]};
            ey[i] = {{(EW-COORD_W){vy[i][COORD_W-1]}}, vy[i]};
        end
        dx[0] = ex[1] - ex[0];
        dy[0] = ey[1] - ey[0];
        dx[1] = ex[2] - ex[1];
        dy[1] = ey[2] - ey[1];
        dx[2] = ex[0] - ex[2];
        dy[2] = ey[0] - ey[2];
        area_raw = dx[0] * (ey[2] - ey[0]) - dy[0] * (ex[2] - ex[0]);
        neg = area_raw[EW-1];

        xlo = (ex[0] < ex[1]) ? ex[0] : ex[1];
        xlo = (ex[2] < xlo) ? ex[2] : xlo;
        xhi = (ex[0] > ex[1]) ? ex[0] : ex[1];
        xhi = (ex[2] > xhi) ? ex[2] : xhi;
        ylo = (ey[0] < ey[1]) ? ey[0] : ey[1];
        ylo = (ey[2] < ylo) ? ey[2] : ylo;
        yhi = (ey[0] > ey[1]) ? ey[0] : ey[1];
        yhi = (ey[2] > yhi) ? ey[2] : yhi;
        xmin_c = (xlo < 0) ? '0 : xlo;
        ymin_c = (ylo < 0) ? '0 : ylo;
        xmax_c = (xhi > X_LIM) ? X_LIM : xhi;
        ymax_c = (yhi > Y_LIM) ? Y_LIM : yhi;
        off_screen = (xmin_c > xmax_c) || (ymin_c > ymax_c);

        for (int i = 0; i < 3; i++) begin
            e_raw[i]   = dx[i] * (ymin_c - ey[i]) - dy[i] * (xmin_c - ex[i]);
            e_start[i] = neg ? -e_raw[i] : e_raw[i];
        end
    end

    always_comb begin
        cov = '0;
        for (int i = 0; i < 3; i++) begin
`ifdef TRI_RASTER_TOP_LEFT_EN
            // Inclusive edge: normalised (by-ay) > 0, or horizontal running leftwards.
            cov[i] = (e_cur[i] > 0) ||
                     ((e_cur[i] == 0) && ((step_x[i] < 0) || ((step_x[i] == 0) && (step_y[i] < 0))));
`else
            cov[i] = !e_cur[i][EW-1];
`endif
        end
        covered = &cov;
        advance = !covered || i_pix_ready;
        last    = (cx == xmax) && (cy == ymax);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_tri_valid) state_nx = SETUP;
            SETUP:   state_nx = ((area_raw == 0) || off_screen) ? DONE : SCAN;
            SCAN:    if (advance && last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_tri_ready = (state == IDLE);
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        o_pix_valid = (state == SCAN) && covered;
        o_pix_x     = cx;
        o_pix_y     = cy;
        o_pix_w1    = e_cur[0];
        o_pix_w2    = e_cur[1];
        o_pix_w3    = e_cur[2];
        o_pix_area  = area;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 3; i++) begin
                vx[i]     <= '0;
                vy[i]     <= '0;
                e_cur[i]  <= '0;
                e_row[i]  <= '0;
                step_x[i] <= '0;
                step_y[i] <= '0;
            end
            area <= '0;
            cx   <= '0;
            cy   <= '0;
            xmin <= '0;
            xmax <= '0;
            ymax <= '0;
        end else begin
            case (state)
                IDLE: if (i_tri_valid) begin
                    vx[0] <= i_v1x; vy[0] <= i_v1y;
                    vx[1] <= i_v2x; vy[1] <= i_v2y;
                    vx[2] <= i_v3x; vy[2] <= i_v3y;
                end
                SETUP: begin
                    for (int i = 0; i < 3; i++) begin
                        e_cur[i]  <= e_start[i];
                        e_row[i]  <= e_start[i];
                        step_x[i] <= neg ? dy[i] : -dy[i];
                        step_y[i] <= neg ? -dx[i] : dx[i];
                    end
                    area <= neg ? -area_raw : area_raw;
                    cx   <= xmin_c[COORD_W-1:0];
                    cy   <= ymin_c[COORD_W-1:0];
                    xmin <= xmin_c[COORD_W-1:0];
                    xmax <= xmax_c[COORD_W-1:0];
                    ymax <= ymax_c[COORD_W-1:0];
                end
                SCAN: if (advance && !last) begin
                    if (cx == xmax) begin
                        cx <= xmin;
                        cy <= cy + ONE_C;
                        for (int i = 0; i < 3; i++) begin
                            e_row[i] <= e_row[i] + step_y[i];
                            e_cur[i] <= e_row[i] + step_y[i];
                        end
                    end else begin
                        cx <= cx + ONE_C;
                        for (int i = 0; i < 3; i++) e_cur[i] <= e_cur[i] + step_x[i];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
